// File: rtl/jump_target_gen_if.sv
// Request/result bundle for jump_target_gen: the decode-side request with its
// handshake, the flush, and the registered target with its status flags.
interface jump_target_gen_if #(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 12
);
    logic              Flush;
    logic              In_Valid;
    logic              In_Ready;
    logic [1:0]        Mode;
    logic [ADDR_W-1:0] PC_In;
    logic [IMM_W-1:0]  Imm_In;
    logic [ADDR_W-1:0] Reg_In;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [ADDR_W-1:0] Target_Out;
    logic              Page_Cross;
    logic              Bad_Mode;

    modport master (
        output Flush, In_Valid, Mode, PC_In, Imm_In, Reg_In, Out_Ready,
        input  In_Ready, Out_Valid, Target_Out, Page_Cross, Bad_Mode
    );

    modport slave (
        input  Flush, In_Valid, Mode, PC_In, Imm_In, Reg_In, Out_Ready,
        output In_Ready, Out_Valid, Target_Out, Page_Cross, Bad_Mode
    );
endinterface

// File: rtl/jump_target_gen.sv
// Registered branch/jump target generator: append, PC-relative or
// register-indirect addressing behind a one-entry valid/ready output stage.
module jump_target_gen #(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 12
) (
    input logic               CLK,
    input logic               Reset_n,
    jump_target_gen_if.slave  bus
);
    localparam int PAGE_W = ADDR_W - IMM_W;

    localparam logic [1:0] MODE_APPEND   = 2'b00;
    localparam logic [1:0] MODE_RELATIVE = 2'b01;
    localparam logic [1:0] MODE_INDIRECT = 2'b10;

    logic              out_valid;
    logic [ADDR_W-1:0] target_q;
    logic              page_cross_q;
    logic              bad_mode_q;

    logic              in_ready;
    logic              accept;
    logic [ADDR_W-1:0] next_target;
    logic              next_page_cross;
    logic              next_bad_mode;
    logic [ADDR_W-1:0] imm_sext;

    // The stage frees up when empty or when its entry drains this same cycle.
    assign in_ready = Reset_n && (!out_valid || bus.Out_Ready);
    assign accept   = bus.In_Valid && in_ready && !bus.Flush;
    assign imm_sext = {{PAGE_W{bus.Imm_In[IMM_W-1]}}, bus.Imm_In};

    always_comb begin
        next_target     = bus.PC_In;
        next_bad_mode   = 1'b0;
        next_page_cross = 1'b0;
        case (bus.Mode)
            MODE_APPEND:   next_target = {bus.PC_In[ADDR_W-1:IMM_W], bus.Imm_In};
            MODE_RELATIVE: next_target = bus.PC_In + imm_sext;
            MODE_INDIRECT: next_target = bus.Reg_In;
            default: begin
                next_target   = bus.PC_In;
                next_bad_mode = 1'b1;
            end
        endcase
        if (!next_bad_mode) begin
            next_page_cross = (next_target[ADDR_W-1:IMM_W] != bus.PC_In[ADDR_W-1:IMM_W]);
        end
    end

    // Reset beats flush, flush beats any handshake.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            out_valid    <= 1'b0;
            target_q     <= '0;
            page_cross_q <= 1'b0;
            bad_mode_q   <= 1'b0;
        end else if (bus.Flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            target_q     <= next_target;
            page_cross_q <= next_page_cross;
            bad_mode_q   <= next_bad_mode;
        end else if (bus.Out_Ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.Out_Valid  = out_valid;
    assign bus.Target_Out = target_q;
    assign bus.Page_Cross = page_cross_q;
    assign bus.Bad_Mode   = bad_mode_q;
endmodule

// File: tb/tb_jump_target_gen.sv
// Directed bench for jump_target_gen: a vector table for the addressing modes
// plus hand-written stall, flush, reset and 32/16 parameter sequences.
module tb_jump_target_gen;
    logic CLK;
    logic Reset_n;

    jump_target_gen_if #(.ADDR_W(16), .IMM_W(12)) bus ();
    jump_target_gen_if #(.ADDR_W(32), .IMM_W(16)) bus32 ();

    jump_target_gen #(.ADDR_W(16), .IMM_W(12)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    jump_target_gen #(.ADDR_W(32), .IMM_W(16)) dut32 (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus32.slave)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] pc;
        logic [11:0] imm;
        logic [15:0] reg_v;
        logic [15:0] target;
        logic        page;
        logic        bad;
    } vec_t;

    vec_t vecs [10];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] mode, input logic [15:0] pc,
                                  input logic [11:0] imm, input logic [15:0] reg_v, input logic ready);
        bus.In_Valid  = valid;
        bus.Mode      = mode;
        bus.PC_In     = pc;
        bus.Imm_In    = imm;
        bus.Reg_In    = reg_v;
        bus.Out_Ready = ready;
    endtask

    task automatic check_result(input string tag, input logic valid, input logic [15:0] target,
                                input logic page, input logic bad);
        check_output({tag, "_valid"}, 32'(bus.Out_Valid), 32'(valid));
        check_output({tag, "_target"}, 32'(bus.Target_Out), 32'(target));
        check_output({tag, "_page"}, 32'(bus.Page_Cross), 32'(page));
        check_output({tag, "_bad"}, 32'(bus.Bad_Mode), 32'(bad));
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'h4ABC, 12'h567, 16'h0000, 16'h4567, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 16'h4FF0, 12'h020, 16'h0000, 16'h5010, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 16'h0000, 12'hFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 16'h1000, 12'h0AB, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 16'h2222, 12'h123, 16'h5555, 16'h2222, 1'b0, 1'b1};
        vecs[5] = '{2'b01, 16'h4100, 12'h800, 16'h0000, 16'h3900, 1'b1, 1'b0};
        vecs[6] = '{2'b01, 16'h4100, 12'h7FF, 16'h0000, 16'h48FF, 1'b0, 1'b0};
        vecs[7] = '{2'b10, 16'h1000, 12'h000, 16'h9000, 16'h9000, 1'b1, 1'b0};
        vecs[8] = '{2'b00, 16'hFFFF, 12'h000, 16'h0000, 16'hF000, 1'b0, 1'b0};
        vecs[9] = '{2'b01, 16'hFFFF, 12'h001, 16'h0000, 16'h0000, 1'b1, 1'b0};

        Reset_n    = 1'b0;
        bus.Flush  = 1'b0;
        apply_stimulus(1'b1, 2'b01, 16'h1234, 12'h111, 16'h0000, 1'b1);
        bus32.Flush     = 1'b0;
        bus32.In_Valid  = 1'b0;
        bus32.Mode      = 2'b00;
        bus32.PC_In     = '0;
        bus32.Imm_In    = '0;
        bus32.Reg_In    = '0;
        bus32.Out_Ready = 1'b1;

        step;
        step;
        check_result("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        check_output("reset_in_ready", 32'(bus.In_Ready), 32'd0);
        Reset_n = 1'b1;
        apply_stimulus(1'b0, 2'b00, 16'h0000, 12'h000, 16'h0000, 1'b1);
        #1;
        check_output("release_in_ready", 32'(bus.In_Ready), 32'd1);

        // Back-to-back table: one accept per edge, result visible after it.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, vecs[i].mode, vecs[i].pc, vecs[i].imm, vecs[i].reg_v, 1'b1);
            step;
            check_result($sformatf("vec%0d", i), 1'b1, vecs[i].target, vecs[i].page, vecs[i].bad);
        end
        apply_stimulus(1'b0, 2'b00, 16'h0000, 12'h000, 16'h0000, 1'b1);
        step;
        check_output("drain_valid", 32'(bus.Out_Valid), 32'd0);
        check_output("drain_keep_target", 32'(bus.Target_Out), 32'h0000);

        // Backpressure: first result held while a second request waits.
        apply_stimulus(1'b1, 2'b10, 16'h1000, 12'h000, 16'hAAAA, 1'b0);
        step;
        check_result("bp_first", 1'b1, 16'hAAAA, 1'b1, 1'b0);
        apply_stimulus(1'b1, 2'b10, 16'hB000, 12'h000, 16'hBBBB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("bp_in_ready%0d", i), 32'(bus.In_Ready), 32'd0);
            step;
            check_result($sformatf("bp_hold%0d", i), 1'b1, 16'hAAAA, 1'b1, 1'b0);
        end
        bus.Out_Ready = 1'b1;
        #1;
        check_output("bp_in_ready_release", 32'(bus.In_Ready), 32'd1);
        step;
        check_result("bp_second", 1'b1, 16'hBBBB, 1'b0, 1'b0);
        apply_stimulus(1'b0, 2'b00, 16'h0000, 12'h000, 16'h0000, 1'b1);
        step;
        check_output("bp_drain_valid", 32'(bus.Out_Valid), 32'd0);

        // Flush with a live result and a pending request.
        apply_stimulus(1'b1, 2'b10, 16'h1000, 12'h000, 16'hCCCC, 1'b0);
        step;
        check_result("flush_pre", 1'b1, 16'hCCCC, 1'b1, 1'b0);
        bus.Flush = 1'b1;
        apply_stimulus(1'b1, 2'b10, 16'h1000, 12'h000, 16'hDDDD, 1'b1);
        step;
        check_output("flush_valid", 32'(bus.Out_Valid), 32'd0);
        bus.Flush = 1'b0;
        apply_stimulus(1'b0, 2'b00, 16'h0000, 12'h000, 16'h0000, 1'b1);
        step;
        check_output("flush_not_taken", 32'(bus.Out_Valid), 32'd0);

        // Reset arriving while stalled.
        apply_stimulus(1'b1, 2'b11, 16'hEEEE, 12'h000, 16'h0000, 1'b0);
        step;
        check_result("rst_stall_pre", 1'b1, 16'hEEEE, 1'b0, 1'b1);
        Reset_n = 1'b0;
        bus.Out_Ready = 1'b1;
        #1;
        check_output("rst_stall_in_ready", 32'(bus.In_Ready), 32'd0);
        step;
        check_result("rst_stall", 1'b0, 16'h0000, 1'b0, 1'b0);
        Reset_n = 1'b1;
        apply_stimulus(1'b0, 2'b00, 16'h0000, 12'h000, 16'h0000, 1'b1);
        #1;
        check_output("rst_stall_release_ready", 32'(bus.In_Ready), 32'd1);
        step;

        // Wider instance: 32-bit addresses, 16-bit immediates.
        bus32.In_Valid = 1'b1;
        bus32.Mode     = 2'b01;
        bus32.PC_In    = 32'h0001_FFF0;
        bus32.Imm_In   = 16'h0010;
        step;
        check_output("w32_rel_valid", 32'(bus32.Out_Valid), 32'd1);
        check_output("w32_rel_target", bus32.Target_Out, 32'h0002_0000);
        check_output("w32_rel_page", 32'(bus32.Page_Cross), 32'd1);
        bus32.PC_In  = 32'h0002_0000;
        bus32.Imm_In = 16'h8000;
        step;
        check_output("w32_neg_target", bus32.Target_Out, 32'h0001_8000);
        check_output("w32_neg_page", 32'(bus32.Page_Cross), 32'd1);
        bus32.Mode   = 2'b00;
        bus32.PC_In  = 32'h1234_5678;
        bus32.Imm_In = 16'hABCD;
        step;
        check_output("w32_app_target", bus32.Target_Out, 32'h1234_ABCD);
        check_output("w32_app_page", 32'(bus32.Page_Cross), 32'd0);
        check_output("w32_app_bad", 32'(bus32.Bad_Mode), 32'd0);
        bus32.In_Valid = 1'b0;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jump_target_gen.md
Name: jump_target_gen

Overview:
- Parametrised, registered successor to the 4+12 PC/immediate append stage.
- Forms a branch/jump target address from the current PC, an immediate field and a register operand, under one of three addressing modes.
- Sits between decode and PC-select logic.
- Adds a valid/ready handshake with a one-entry output register, a flush, page-crossing detection and illegal-mode flagging.

Parameters:
- ADDR_W, 16, address/PC width in bits.
- IMM_W, 12, immediate width in bits; must satisfy 1 <= IMM_W < ADDR_W.

Ports:
- CLK  input  1  rising-edge clock.
- Reset_n  input  1  synchronous active-low reset.
- Flush  input  1  synchronous clear of the held result (pipeline squash).
- In_Valid  input  1  request present.
- In_Ready  output  1  block can accept a request this cycle.
- Mode  input  2  00 append, 01 PC-relative, 10 register-indirect, 11 illegal.
- PC_In  input  ADDR_W  current PC.
- Imm_In  input  IMM_W  immediate field.
- Reg_In  input  ADDR_W  register operand for indirect mode.
- Out_Valid  output  1  Target_Out holds a result.
- Out_Ready  input  1  consumer accepts the result this cycle.
- Target_Out  output  ADDR_W  computed target.
- Page_Cross  output  1  Target_Out[ADDR_W-1:IMM_W] differs from PC_In[ADDR_W-1:IMM_W] of the same request.
- Bad_Mode  output  1  the request used Mode 11.

Behaviour:
- Reset: when Reset_n=0 at a rising CLK edge, Out_Valid, Target_Out, Page_Cross and Bad_Mode all go to 0. Reset has priority over Flush and over any handshake. A request in flight during reset is discarded.
- In_Ready = !Out_Valid || Out_Ready (combinational). In_Ready is 0 during the reset cycle.
- Accept: a request is accepted on an edge where In_Valid && In_Ready && !Flush.
  - On accept, the result registers load and Out_Valid=1 on the next cycle. Latency is 1 cycle.
- Hold: if Out_Valid && !Out_Ready, all outputs hold stable and no new request is accepted. Inputs must not be sampled while stalled.
- Consume with no new request: if Out_Valid && Out_Ready && !(In_Valid accepted), Out_Valid goes to 0 next cycle. Target_Out keeps its last value (don't care).
- Simultaneous consume and accept in the same cycle: the new result replaces the old one. Out_Valid stays 1, giving back-to-back throughput of one per cycle.
- Flush=1 (Reset_n=1): Out_Valid goes to 0 next cycle and no request is accepted that cycle, regardless of In_Valid or Out_Ready.
- Mode 00, append: Target = {PC_In[ADDR_W-1:IMM_W], Imm_In}.
- Mode 01, relative: Target = (PC_In + sign_extend(Imm_In)) mod 2^ADDR_W. Wrap-around in both directions is silent, with no overflow flag.
- Mode 10, indirect: Target = Reg_In. Imm_In is ignored.
- Mode 11, illegal: Target = PC_In, Bad_Mode=1, Page_Cross=0. The result is still delivered via the normal handshake.
- Page_Cross is computed for all legal modes. It is always 0 for mode 00 by construction.
- Bad_Mode is 0 for modes 00, 01 and 10.
- Page_Cross and Bad_Mode are registered together with Target_Out and are valid only while Out_Valid=1.
- No state machine beyond the single valid bit. Implementation is a pure registered datapath plus handshake control.

Test Plan:
- Reset, then Mode=00, PC_In=0x4ABC, Imm_In=0x567, In_Valid=1, Out_Ready=1 -> next cycle Out_Valid=1, Target_Out=0x4567, Page_Cross=0, Bad_Mode=0 (defaults 16/12).
- Mode=01, PC_In=0x4FF0, Imm_In=0x020 -> Target_Out=0x5010, Page_Cross=1. Then PC_In=0x0000, Imm_In=0xFFF -> Target_Out=0xFFFF (negative wrap), Page_Cross=1.
- Mode=10, Reg_In=0x1234, PC_In=0x1000 -> Target_Out=0x1234, Page_Cross=0. Then Mode=11, PC_In=0x2222 -> Target_Out=0x2222, Bad_Mode=1.
- Backpressure: hold Out_Ready=0 for 3 cycles after one accept -> In_Ready=0, outputs frozen, a second request is not taken. Raise Out_Ready with the second request still valid -> second result appears the following cycle, Out_Valid never drops.
- Flush while Out_Valid=1 and In_Valid=1 -> Out_Valid=0 next cycle and the pending request is not accepted. Drive Reset_n=0 mid-stall -> all outputs 0 next cycle, In_Ready=1 after release.
- Parameter sweep ADDR_W=32, IMM_W=16, Mode=01, PC_In=0x0001_FFF0, Imm_In=0x0010 -> Target_Out=0x0002_0000, Page_Cross=1.
